// File: rtl/hybrid_slot_buffer_pkg.sv
// Shared types and sizing helpers for the multi-slot hybrid feature buffer.
package hybrid_buffer_pkg;

  // Per-slot lifecycle.
  typedef enum logic [1:0] {
    FREE     = 2'd0,
    WRITING  = 2'd1,
    DRAINING = 2'd2
  } slot_state_t;

  // Number of narrow read words held by one slot.
  function automatic int read_depth(input int write_depth, input int ratio);
    return write_depth * ratio;
  endfunction

  // Width of a lane index; kept at least one bit so RATIO=1 still elaborates.
  function automatic int lane_bits(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/hybrid_slot_buffer_if.sv
// Bus bundle between the aggregation side (master) and the slot buffer (slave).
interface hybrid_slot_buffer_if
  import hybrid_buffer_pkg::*;
#(
  parameter int NUM_SLOTS     = 8,
  parameter int READ_WIDTH    = 32,
  parameter int RATIO         = 2,
  parameter int WRITE_DEPTH   = 256,
  parameter int SLOT_ID_WIDTH = 20
);
  localparam int WRITE_WIDTH = READ_WIDTH * RATIO;
  localparam int READ_DEPTH  = read_depth(WRITE_DEPTH, RATIO);
  localparam int SW          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int AW          = $clog2(WRITE_DEPTH);
  localparam int CW          = $clog2(READ_DEPTH) + 1;

  // Allocation
  logic                                   alloc_req;
  logic [SLOT_ID_WIDTH-1:0]               alloc_node_id;
  logic                                   alloc_grant;
  logic [SW-1:0]                          alloc_slot;
  // RAM-style writes
  logic [NUM_SLOTS-1:0]                   write_enable;
  logic [NUM_SLOTS-1:0][AW-1:0]           write_address;
  logic [NUM_SLOTS-1:0][WRITE_WIDTH-1:0]  write_data;
  // Lifecycle control ('release' is a language keyword, hence release_slot)
  logic [NUM_SLOTS-1:0]                   commit_valid;
  logic [NUM_SLOTS-1:0][CW-1:0]           commit_count;
  logic [NUM_SLOTS-1:0]                   release_slot;
  // Drain ports
  logic [NUM_SLOTS-1:0]                   out_valid;
  logic [NUM_SLOTS-1:0]                   out_ready;
  logic [NUM_SLOTS-1:0][READ_WIDTH-1:0]   out_feature;
  logic [NUM_SLOTS-1:0][CW-1:0]           feature_count;
  // Status
  logic [NUM_SLOTS-1:0]                   slot_free;
  logic [NUM_SLOTS-1:0][SLOT_ID_WIDTH-1:0] slot_node_id;
  logic [NUM_SLOTS-1:0]                   write_error;

  modport master (
    output alloc_req, alloc_node_id, write_enable, write_address, write_data,
           commit_valid, commit_count, release_slot, out_ready,
    input  alloc_grant, alloc_slot, out_valid, out_feature, feature_count,
           slot_free, slot_node_id, write_error
  );

  modport slave (
    input  alloc_req, alloc_node_id, write_enable, write_address, write_data,
           commit_valid, commit_count, release_slot, out_ready,
    output alloc_grant, alloc_slot, out_valid, out_feature, feature_count,
           slot_free, slot_node_id, write_error
  );

endinterface

// File: rtl/hybrid_slot_buffer_unit.sv
// One buffer slot: wide-write RAM, FREE/WRITING/DRAINING lifecycle and a
// prefetch + skid drain path that sustains one narrow word per cycle.
module hybrid_slot_unit
  import hybrid_buffer_pkg::*;
#(
  parameter int  READ_WIDTH    = 32,
  parameter int  RATIO         = 2,
  parameter int  WRITE_DEPTH   = 256,
  parameter int  SLOT_ID_WIDTH = 20,
  localparam int WRITE_WIDTH   = READ_WIDTH * RATIO,
  localparam int READ_DEPTH    = read_depth(WRITE_DEPTH, RATIO),
  localparam int AW            = $clog2(WRITE_DEPTH),
  localparam int PW            = $clog2(READ_DEPTH),
  localparam int CW            = PW + 1,
  localparam int LW            = lane_bits(RATIO),
  localparam int LOG_RATIO     = $clog2(RATIO)
)(
  input  logic                     core_clk,
  input  logic                     resetn,
  input  logic                     grant,
  input  logic [SLOT_ID_WIDTH-1:0] node_id,
  input  logic                     write_enable,
  input  logic [AW-1:0]            write_address,
  input  logic [WRITE_WIDTH-1:0]   write_data,
  input  logic                     commit_valid,
  input  logic [CW-1:0]            commit_count,
  input  logic                     release_slot,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [READ_WIDTH-1:0]    out_feature,
  output logic [CW-1:0]            feature_count,
  output logic                     slot_free,
  output logic [SLOT_ID_WIDTH-1:0] slot_node_id,
  output logic                     write_error
);

  slot_state_t              state_reg, state_next;
  logic [CW-1:0]            count_reg, count_next;   // words still to hand out
  logic [CW-1:0]            fetch_reg, fetch_next;   // words still to read from RAM
  logic [PW-1:0]            ptr_reg, ptr_next;       // next read-word index to fetch
  logic                     pf_valid_reg, pf_valid_next;
  logic [LW-1:0]            pf_lane_reg, pf_lane_next;
  logic                     skid_valid_reg, skid_valid_next;
  logic [READ_WIDTH-1:0]    skid_data_reg, skid_data_next;
  logic [SLOT_ID_WIDTH-1:0] node_reg, node_next;
  logic                     error_reg, error_next;

  logic [WRITE_WIDTH-1:0]   mem [WRITE_DEPTH];
  logic [WRITE_WIDTH-1:0]   ram_q;
  logic [AW-1:0]            rd_addr;
  logic [READ_WIDTH-1:0]    pf_data;
  logic [CW-1:0]            clamp_count;
  logic                     issue;
  logic                     fire;
  logic                     ram_we;

  // Prefetch stage presents directly; the skid only fills when the prefetch
  // must be overwritten while the consumer is stalled.
  assign pf_data     = ram_q[int'(pf_lane_reg) * READ_WIDTH +: READ_WIDTH];
  assign out_valid   = skid_valid_reg | pf_valid_reg;
  assign out_feature = skid_valid_reg ? skid_data_reg : pf_data;
  assign fire        = out_valid & out_ready;

  // Fetch only when the skid is empty, so a stall can never lose the prefetch.
  assign issue   = (state_reg == DRAINING) && (fetch_reg != '0) && !skid_valid_reg;
  assign rd_addr = AW'(ptr_reg >> LOG_RATIO);
  assign ram_we  = write_enable && (state_reg == WRITING) && !release_slot;

  assign clamp_count = (commit_count > CW'(READ_DEPTH)) ? CW'(READ_DEPTH) : commit_count;

  assign feature_count = count_reg;
  assign slot_free     = (state_reg == FREE);
  assign slot_node_id  = node_reg;
  assign write_error   = error_reg;

  // Slot RAM: legal writes only, registered read on fetch (contents never cleared).
  always_ff @(posedge core_clk) begin
    if (ram_we) mem[write_address] <= write_data;
    if (issue)  ram_q <= mem[rd_addr];
  end

  // State and datapath registers.
  always_ff @(posedge core_clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= FREE;
      count_reg      <= '0;
      fetch_reg      <= '0;
      ptr_reg        <= '0;
      pf_valid_reg   <= 1'b0;
      pf_lane_reg    <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      node_reg       <= '0;
      error_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      fetch_reg      <= fetch_next;
      ptr_reg        <= ptr_next;
      pf_valid_reg   <= pf_valid_next;
      pf_lane_reg    <= pf_lane_next;
      skid_valid_reg <= skid_valid_next;
      skid_data_reg  <= skid_data_next;
      node_reg       <= node_next;
      error_reg      <= error_next;
    end
  end

  // Lifecycle next-state, drain pipeline control and error tracking.
  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    fetch_next      = fetch_reg;
    ptr_next        = ptr_reg;
    pf_valid_next   = pf_valid_reg;
    pf_lane_next    = pf_lane_reg;
    skid_valid_next = skid_valid_reg;
    skid_data_next  = skid_data_reg;
    node_next       = node_reg;
    error_next      = error_reg;

    if (release_slot) begin
      // Abort wins over everything else this cycle, including a grant.
      state_next      = FREE;
      count_next      = '0;
      fetch_next      = '0;
      pf_valid_next   = 1'b0;
      skid_valid_next = 1'b0;
    end else begin
      if (grant) begin
        node_next  = node_id;
        error_next = 1'b0;
      end
      // An illegal strobe in the grant cycle still counts as an error.
      if ((write_enable || commit_valid) && (state_reg != WRITING)) error_next = 1'b1;

      case (state_reg)
        FREE: begin
          if (grant) state_next = WRITING;
        end
        WRITING: begin
          if (commit_valid) begin
            ptr_next   = '0;
            count_next = clamp_count;
            fetch_next = clamp_count;
            state_next = (clamp_count == '0) ? FREE : DRAINING;
          end
        end
        DRAINING: begin
          if (issue) begin
            ptr_next      = ptr_reg + PW'(1);
            fetch_next    = fetch_reg - CW'(1);
            pf_lane_next  = LW'(ptr_reg % RATIO);
            pf_valid_next = 1'b1;
            // Prefetch is being replaced while its word is still owed: park it.
            if (pf_valid_reg && !fire) begin
              skid_valid_next = 1'b1;
              skid_data_next  = pf_data;
            end
          end else if (skid_valid_reg) begin
            if (fire) skid_valid_next = 1'b0;
          end else if (fire) begin
            pf_valid_next = 1'b0;
          end

          if (fire) begin
            count_next = count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
              state_next      = FREE;
              fetch_next      = '0;
              pf_valid_next   = 1'b0;
              skid_valid_next = 1'b0;
            end
          end
        end
        default: state_next = FREE;
      endcase
    end
  end

endmodule

// File: rtl/hybrid_slot_buffer.sv
// Top level: lowest-index free-slot allocator plus one hybrid_slot_unit per slot.
module hybrid_slot_buffer
  import hybrid_buffer_pkg::*;
#(
  parameter int NUM_SLOTS     = 8,
  parameter int READ_WIDTH    = 32,
  parameter int RATIO         = 2,
  parameter int WRITE_DEPTH   = 256,
  parameter int SLOT_ID_WIDTH = 20
)(
  input logic                 core_clk,
  input logic                 resetn,
  hybrid_slot_buffer_if.slave bus
);

  localparam int READ_DEPTH = read_depth(WRITE_DEPTH, RATIO);
  localparam int SW         = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW         = $clog2(READ_DEPTH) + 1;

  logic [NUM_SLOTS-1:0]                    free_vec;
  logic [NUM_SLOTS-1:0]                    grant_vec;
  logic [NUM_SLOTS-1:0]                    valid_vec;
  logic [NUM_SLOTS-1:0][READ_WIDTH-1:0]    feature_vec;
  logic [NUM_SLOTS-1:0][CW-1:0]            count_vec;
  logic [NUM_SLOTS-1:0][SLOT_ID_WIDTH-1:0] node_vec;
  logic [NUM_SLOTS-1:0]                    error_vec;
  logic [SW-1:0]                           free_idx;

  // Lowest-index FREE slot, from registered state only (a slot freed this
  // cycle is not visible until next cycle).
  always_comb begin
    free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) free_idx = SW'(i);
    end
  end

  assign bus.alloc_grant   = bus.alloc_req & (|free_vec);
  assign bus.alloc_slot    = free_idx;
  assign bus.slot_free     = free_vec;
  assign bus.out_valid     = valid_vec;
  assign bus.out_feature   = feature_vec;
  assign bus.feature_count = count_vec;
  assign bus.slot_node_id  = node_vec;
  assign bus.write_error   = error_vec;

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign grant_vec[gi] = bus.alloc_grant && (free_idx == SW'(gi));

      hybrid_slot_unit #(
        .READ_WIDTH    (READ_WIDTH),
        .RATIO         (RATIO),
        .WRITE_DEPTH   (WRITE_DEPTH),
        .SLOT_ID_WIDTH (SLOT_ID_WIDTH)
      ) u_slot (
        .core_clk      (core_clk),
        .resetn        (resetn),
        .grant         (grant_vec[gi]),
        .node_id       (bus.alloc_node_id),
        .write_enable  (bus.write_enable[gi]),
        .write_address (bus.write_address[gi]),
        .write_data    (bus.write_data[gi]),
        .commit_valid  (bus.commit_valid[gi]),
        .commit_count  (bus.commit_count[gi]),
        .release_slot  (bus.release_slot[gi]),
        .out_ready     (bus.out_ready[gi]),
        .out_valid     (valid_vec[gi]),
        .out_feature   (feature_vec[gi]),
        .feature_count (count_vec[gi]),
        .slot_free     (free_vec[gi]),
        .slot_node_id  (node_vec[gi]),
        .write_error   (error_vec[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_hybrid_slot_buffer.sv
// Directed bench for hybrid_slot_buffer (16-bit read lanes, RATIO=2, 8 slots).
module tb_hybrid_slot_buffer;
  import hybrid_buffer_pkg::*;

  localparam int NS  = 8;
  localparam int RW  = 16;
  localparam int RAT = 2;
  localparam int WD  = 256;
  localparam int IDW = 20;

  logic core_clk = 1'b0;
  logic resetn   = 1'b0;
  int   n_total  = 0;
  int   n_pass   = 0;

  always #5 core_clk = ~core_clk;

  hybrid_slot_buffer_if #(.NUM_SLOTS(NS), .READ_WIDTH(RW), .RATIO(RAT),
                          .WRITE_DEPTH(WD), .SLOT_ID_WIDTH(IDW)) bus ();

  hybrid_slot_buffer #(.NUM_SLOTS(NS), .READ_WIDTH(RW), .RATIO(RAT),
                       .WRITE_DEPTH(WD), .SLOT_ID_WIDTH(IDW)) dut (
    .core_clk (core_clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 2ns after the edge.
  task automatic cyc();
    @(posedge core_clk);
    #2;
  endtask

  task automatic write_word(input int s, input int addr, input logic [31:0] d);
    bus.write_enable[s]  = 1'b1;
    bus.write_address[s] = 8'(addr);
    bus.write_data[s]    = d;
    cyc();
    bus.write_enable[s]  = 1'b0;
    $display("write slot %0d addr %0d data 0x%08h", s, addr, d);
  endtask

  task automatic alloc(input logic [19:0] id, input int exp_slot);
    bus.alloc_req     = 1'b1;
    bus.alloc_node_id = id;
    #1;
    check("alloc_grant", bus.alloc_grant, 1);
    check("alloc_slot", bus.alloc_slot, exp_slot);
    cyc();
    bus.alloc_req = 1'b0;
    $display("alloc id 0x%05h -> slot %0d", id, exp_slot);
  endtask

  initial begin : stim
    int k;
    logic r;
    logic [15:0] lo;

    bus.alloc_req     = 1'b0;
    bus.alloc_node_id = '0;
    bus.write_enable  = '0;
    bus.write_address = '0;
    bus.write_data    = '0;
    bus.commit_valid  = '0;
    bus.commit_count  = '0;
    bus.release_slot  = '0;
    bus.out_ready     = '0;

    // ---- reset values ----
    repeat (3) cyc();
    check("rst_slot_free", bus.slot_free, 8'hFF);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_write_error", bus.write_error, 0);
    check("rst_fcount_any", {63'b0, |bus.feature_count}, 0);
    check("rst_node_any", {63'b0, |bus.slot_node_id}, 0);
    bus.alloc_req = 1'b1;
    #1;
    check("rst_grant_follows_req", bus.alloc_grant, 1);
    bus.alloc_req = 1'b0;
    #1;
    check("rst_grant_idle", bus.alloc_grant, 0);
    resetn = 1'b1;
    cyc();

    // ---- first allocation ----
    alloc(20'h00123, 0);
    check("alloc_free_mask", bus.slot_free, 8'hFE);
    check("alloc_node_id0", bus.slot_node_id[0], 20'h00123);

    // ---- RATIO=2 lane order, commit shares a cycle with the last write ----
    write_word(0, 0, 32'hBBBB_AAAA);
    bus.out_ready[0]     = 1'b1;
    bus.commit_valid[0]  = 1'b1;
    bus.commit_count[0]  = 10'd4;
    bus.write_enable[0]  = 1'b1;
    bus.write_address[0] = 8'd1;
    bus.write_data[0]    = 32'hDDDD_CCCC;
    cyc();
    bus.commit_valid[0] = 1'b0;
    bus.write_enable[0] = 1'b0;
    check("commit_t1_valid", bus.out_valid[0], 0);
    check("commit_t1_fcount", bus.feature_count[0], 4);
    cyc();
    check("lane_w0_valid", bus.out_valid[0], 1);
    check("lane_w0", bus.out_feature[0], 16'hAAAA);
    check("lane_fc4", bus.feature_count[0], 4);
    cyc();
    check("lane_w1", bus.out_feature[0], 16'hBBBB);
    check("lane_fc3", bus.feature_count[0], 3);
    cyc();
    check("lane_w2", bus.out_feature[0], 16'hCCCC);
    check("lane_fc2", bus.feature_count[0], 2);
    cyc();
    check("lane_w3_valid", bus.out_valid[0], 1);
    check("lane_w3", bus.out_feature[0], 16'hDDDD);
    check("lane_fc1", bus.feature_count[0], 1);
    cyc();
    check("lane_end_valid", bus.out_valid[0], 0);
    check("lane_end_free", bus.slot_free[0], 1);
    check("lane_end_fc", bus.feature_count[0], 0);
    $display("lane-order drain of 4 words done");

    // ---- 100-word drain under random backpressure ----
    alloc(20'h00456, 0);
    for (int i = 0; i < 50; i++) begin
      lo = 16'h1000 + 16'(2 * i);
      write_word(0, i, {lo + 16'd1, lo});
    end
    bus.commit_valid[0] = 1'b1;
    bus.commit_count[0] = 10'd100;
    cyc();
    bus.commit_valid[0] = 1'b0;
    k = 0;
    for (int c = 0; c < 2000 && k < 100; c++) begin
      if (bus.out_valid[0]) begin
        check("bp_word", bus.out_feature[0], 16'h1000 + 16'(k));
        check("bp_fcount", bus.feature_count[0], 100 - k);
        r = ($urandom_range(0, 2) != 0);
        bus.out_ready[0] = r;
        if (r) k++;
      end else begin
        bus.out_ready[0] = 1'($urandom_range(0, 1));
      end
      cyc();
    end
    check("bp_all_words", k, 100);
    check("bp_end_valid", bus.out_valid[0], 0);
    check("bp_end_free", bus.slot_free[0], 1);
    $display("backpressure drain accepted %0d words", k);

    // ---- fill all slots, 9th request, release/grant timing ----
    for (int s = 0; s < NS; s++) alloc(20'h00200 + 20'(s), s);
    check("full_free_mask", bus.slot_free, 0);
    bus.alloc_req     = 1'b1;
    bus.alloc_node_id = 20'hABCDE;
    #1;
    check("full_no_grant", bus.alloc_grant, 0);
    bus.release_slot[3] = 1'b1;
    #1;
    check("release_same_cycle_no_grant", bus.alloc_grant, 0);
    cyc();
    bus.release_slot[3] = 1'b0;
    #1;
    check("release_free_mask", bus.slot_free, 8'h08);
    check("release_grant", bus.alloc_grant, 1);
    check("release_grant_slot", bus.alloc_slot, 3);
    cyc();
    bus.alloc_req = 1'b0;
    check("regrant_free_mask", bus.slot_free, 0);
    check("regrant_node", bus.slot_node_id[3], 20'hABCDE);
    $display("slot 3 released and regranted");

    // ---- zero-count commit, write error and its clear ----
    bus.commit_valid[3] = 1'b1;
    bus.commit_count[3] = 10'd0;
    cyc();
    bus.commit_valid[3] = 1'b0;
    check("zero_commit_free", bus.slot_free[3], 1);
    check("zero_commit_valid", bus.out_valid[3], 0);
    check("zero_commit_error", bus.write_error[3], 0);
    cyc();
    check("zero_commit_valid_later", bus.out_valid[3], 0);
    write_word(3, 7, 32'h1234_5678);
    check("free_write_error", bus.write_error[3], 1);
    alloc(20'h00333, 3);
    check("error_cleared_on_grant", bus.write_error[3], 0);

    // ---- release in the middle of a 10-word drain ----
    for (int i = 0; i < 5; i++) begin
      lo = 16'h3000 + 16'(2 * i);
      write_word(3, i, {lo + 16'd1, lo});
    end
    bus.out_ready[3]    = 1'b1;
    bus.commit_valid[3] = 1'b1;
    bus.commit_count[3] = 10'd10;
    cyc();
    bus.commit_valid[3] = 1'b0;
    cyc();
    for (int j = 0; j < 5; j++) begin
      check("mid_word", bus.out_feature[3], 16'h3000 + 16'(j));
      cyc();
    end
    check("mid_word5", bus.out_feature[3], 16'h3005);
    check("mid_fc_before", bus.feature_count[3], 5);
    bus.release_slot[3] = 1'b1;
    cyc();
    bus.release_slot[3] = 1'b0;
    check("mid_release_valid", bus.out_valid[3], 0);
    check("mid_release_fc", bus.feature_count[3], 0);
    check("mid_release_free", bus.slot_free[3], 1);
    alloc(20'h00777, 3);
    write_word(3, 0, 32'h5555_4444);
    bus.commit_valid[3] = 1'b1;
    bus.commit_count[3] = 10'd2;
    cyc();
    bus.commit_valid[3] = 1'b0;
    cyc();
    check("new_data_w0", bus.out_feature[3], 16'h4444);
    cyc();
    check("new_data_w1", bus.out_feature[3], 16'h5555);
    cyc();
    check("new_data_end", bus.out_valid[3], 0);
    $display("release mid-drain and re-drain done");

    // ---- async reset during a stalled drain ----
    alloc(20'h00999, 3);
    write_word(3, 0, 32'h7777_6666);
    bus.out_ready[3]    = 1'b0;
    bus.commit_valid[3] = 1'b1;
    bus.commit_count[3] = 10'd2;
    cyc();
    bus.commit_valid[3] = 1'b0;
    cyc();
    check("stall_valid", bus.out_valid[3], 1);
    check("stall_word", bus.out_feature[3], 16'h6666);
    cyc();
    check("stall_hold", bus.out_feature[3], 16'h6666);
    resetn = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_free", bus.slot_free, 8'hFF);
    check("async_rst_fc", {63'b0, |bus.feature_count}, 0);
    check("async_rst_node", {63'b0, |bus.slot_node_id}, 0);
    $display("async reset mid-drain done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
